// File: rtl/pixel_fill_pkg.sv
// Shared types and helpers for the directional gap filler.
// FSM encoding, scan direction codes, saturating counter step.
package pixel_fill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CENTER,
    RD_NEG,
    RD_POS,
    WRITE,
    NEXT,
    DONE
  } fill_state_e;

  localparam logic DIR_Y = 1'b0;
  localparam logic DIR_X = 1'b1;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF
                      : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Neighbour address generator for the gap filler.
// Offsets along the scan axis and flags pixels off the image.
import pixel_fill_pkg::*;

module fill_addr_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 18,
  parameter int BASE_ADDR  = 0,
  parameter int ROW_W      = 8,
  parameter int COL_W      = 9,
  parameter int OFF_W      = 4
) (
  input  logic [ROW_W-1:0]        row,
  input  logic [COL_W-1:0]        col,
  input  logic                    direction,
  input  logic signed [OFF_W-1:0] offset,
  output logic [ADDR_W-1:0]       address,
  output logic                    in_bounds
);

  int nr;
  int nc;
  logic signed [ADDR_W:0] full;

  always_comb begin
    nr = int'(row);
    nc = int'(col);
    if (direction == DIR_Y) nr = nr + int'(offset);
    else                    nc = nc + int'(offset);
    full = (ADDR_W+1)'(BASE_ADDR + nr * IMG_WIDTH + nc);
    // a negative sum must never reach the bus
    in_bounds = (nr >= 0) && (nr < IMG_HEIGHT) &&
                (nc >= 0) && (nc < IMG_WIDTH) &&
                !full[ADDR_W];
    address = in_bounds ? full[ADDR_W-1:0] : '0;
  end

endmodule

// File: rtl/directional_gap_filler.sv
// In-place edge gap filler scanning along X or Y.
// Fills a pixel when set pixels lie within gap_len on both sides.
import pixel_fill_pkg::*;

module directional_gap_filler #(
  parameter int                IMG_WIDTH    = 320,
  parameter int                IMG_HEIGHT   = 240,
  parameter int                MARGIN_LINES = 7,
  parameter int                MAX_GAP      = 4,
  parameter int                ADDR_W       = 18,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] FILL_VALUE   = 1,
  parameter int                RD_LAT       = 1,
  parameter int                BASE_ADDR    = 0
) (
  input  logic                           clk_div_by_two,
  input  logic                           reset,
  input  logic                           pause,
  input  logic                           enable,
  input  logic                           direction,
  input  logic [$clog2(MAX_GAP+1)-1:0]   gap_len,
  input  logic [DATA_W-1:0]              data_read,
  output logic                           wren,
  output logic [DATA_W-1:0]              data_write,
  output logic [ADDR_W-1:0]              address,
  output logic                           done,
  output logic [ADDR_W-1:0]              fill_count
);

  localparam int GW    = $clog2(MAX_GAP + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int LW    = $clog2(RD_LAT + 1);

  fill_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [GW-1:0]     k_q, k_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] fill_q, fill_d;

  logic signed [GW:0] off;
  logic [ADDR_W-1:0]  nb_addr;
  logic               nb_in;
  logic [GW-1:0]      gap_clamp;
  logic               hit;
  logic               last;

  fill_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .OFF_W     (GW + 1)
  ) u_addr (
    .row      (row_q),
    .col      (col_q),
    .direction(dir_q),
    .offset   (off),
    .address  (nb_addr),
    .in_bounds(nb_in)
  );

  always_comb begin
    off = '0;
    if (state_q == RD_NEG)      off = -$signed({1'b0, k_q});
    else if (state_q == RD_POS) off = $signed({1'b0, k_q});
  end

  assign gap_clamp  = (gap_len > GW'(MAX_GAP)) ? GW'(MAX_GAP) : gap_len;
  assign hit        = (data_read == FILL_VALUE);
  assign last       = (lat_q == LW'(RD_LAT));
  assign fill_count = fill_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    gap_d      = gap_q;
    lat_d      = lat_q;
    dir_d      = dir_q;
    fill_d     = fill_q;
    wren       = 1'b0;
    data_write = '0;
    address    = '0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          dir_d   = direction;
          gap_d   = gap_clamp;
          fill_d  = '0;
          row_d   = ROW_W'(MARGIN_LINES);
          col_d   = '0;
          lat_d   = '0;
          state_d = (gap_clamp == '0) ? DONE : RD_CENTER;
        end
      end
      RD_CENTER: begin
        address = nb_addr;
        if (last) begin
          lat_d = '0;
          if (hit) begin
            state_d = NEXT;
          end else begin
            k_d     = GW'(1);
            state_d = RD_NEG;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RD_NEG, RD_POS: begin
        // off-image neighbours are one-cycle misses, no read
        if (nb_in) address = nb_addr;
        if (nb_in && !last) begin
          lat_d = lat_q + 1'b1;
        end else if (nb_in && hit) begin
          lat_d   = '0;
          k_d     = GW'(1);
          state_d = (state_q == RD_NEG) ? RD_POS : WRITE;
        end else begin
          lat_d = '0;
          if (k_q >= gap_q) state_d = NEXT;
          else              k_d     = k_q + 1'b1;
        end
      end
      WRITE: begin
        wren       = 1'b1;
        address    = nb_addr;
        data_write = FILL_VALUE;
        fill_d     = ADDR_W'(sat_inc(32'(fill_q), ADDR_W));
        state_d    = NEXT;
      end
      NEXT: begin
        state_d = RD_CENTER;
        if (col_q == COL_W'(IMG_WIDTH - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(IMG_HEIGHT - MARGIN_LINES - 1))
            state_d = DONE;
          else
            row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      fill_d  = '0;
      lat_d   = '0;
    end
  end

  always_ff @(posedge clk_div_by_two) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      lat_q   <= '0;
      dir_q   <= DIR_Y;
      fill_q  <= '0;
    end else if (!pause) begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      lat_q   <= lat_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_directional_gap_filler.sv
// Scoreboard bench for directional_gap_filler on an 8x16 image.
// Expected write addresses are queued; a monitor pops on each write.
module tb_directional_gap_filler;

  localparam int W  = 8;
  localparam int H  = 16;
  localparam int M  = 2;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int GW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, pause, enable, direction;
  logic [GW-1:0] gap_len;
  logic [DW-1:0] data_read, data_write;
  logic          wren, done;
  logic [AW-1:0] address, fill_count;

  logic          en3, dir3;
  logic [GW-1:0] gap3;
  logic [DW-1:0] rd3, wd3;
  logic          wren3, done3;
  logic [AW-1:0] addr3, fc3;

  directional_gap_filler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MARGIN_LINES(M),
    .MAX_GAP(4), .ADDR_W(AW), .DATA_W(DW),
    .FILL_VALUE(32'd1), .RD_LAT(1), .BASE_ADDR(0)
  ) dut (
    .clk_div_by_two(clk), .reset(reset), .pause(pause),
    .enable(enable), .direction(direction), .gap_len(gap_len),
    .data_read(data_read), .wren(wren), .data_write(data_write),
    .address(address), .done(done), .fill_count(fill_count)
  );

  directional_gap_filler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MARGIN_LINES(M),
    .MAX_GAP(4), .ADDR_W(AW), .DATA_W(DW),
    .FILL_VALUE(32'd1), .RD_LAT(3), .BASE_ADDR(0)
  ) dut3 (
    .clk_div_by_two(clk), .reset(reset), .pause(1'b0),
    .enable(en3), .direction(dir3), .gap_len(gap3),
    .data_read(rd3), .wren(wren3), .data_write(wd3),
    .address(addr3), .done(done3), .fill_count(fc3)
  );

  assign rd3 = '0;

  logic [DW-1:0] img [W*H];
  logic [DW-1:0] mem [W*H];
  logic [DW-1:0] rd_pipe;
  logic          load;

  always @(posedge clk) begin
    if (load) begin
      mem <= img;
    end else if (!pause) begin
      rd_pipe <= mem[address[6:0]];
      if (wren) mem[address[6:0]] <= data_write;
    end
  end
  assign data_read = rd_pipe;

  logic [AW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  logic wren3_seen = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wren && !pause) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d, none expected",
                 address);
      end else begin
        check("write_addr", 64'(address), 64'(exp_q.pop_front()));
        check("write_data", 64'(data_write), 64'd1);
      end
    end
    if (wren3) wren3_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    foreach (img[i]) img[i] = '0;
  endtask

  task automatic setpx(input int r, input int c);
    img[r*W + c] = 32'd1;
  endtask

  task automatic load_img();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, 64'(wren), 64'd0);
    check({tag, "_data"}, 64'(data_write), 64'd0);
    check({tag, "_addr"}, 64'(address), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_fill"}, 64'(fill_count), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic run_pass(input string tag, input logic dir,
                          input logic [GW-1:0] g, input int exp_fill);
    direction = dir;
    gap_len   = g;
    enable    = 1'b1;
    wait_done(tag, 4000);
    check({tag, "_fill_count"}, 64'(fill_count), 64'(exp_fill));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    enable = 1'b0;
    tick();
    check({tag, "_idle_done"}, 64'(done), 64'd0);
    check({tag, "_idle_fill"}, 64'(fill_count), 64'd0);
  endtask

  task automatic image_a();
    clear_img();
    setpx(4, 3);
    setpx(7, 3);
    load_img();
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; pause = 1'b0; enable = 1'b0; direction = 1'b0;
    gap_len = '0; load = 1'b0;
    en3 = 1'b0; dir3 = 1'b0; gap3 = '0;
    clear_img();
    load_img();
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    image_a();
    exp_q.push_back(18'd43);
    exp_q.push_back(18'd51);
    run_pass("ygap", 1'b0, 3'd2, 2);
    check("ygap_mem43", 64'(mem[43]), 64'd1);
    check("ygap_mem51", 64'(mem[51]), 64'd1);
    cnt = 0;
    foreach (mem[i]) if (mem[i] != 0) cnt++;
    check("ygap_set_total", 64'(cnt), 64'd4);

    clear_img();
    setpx(4, 1);
    setpx(3, 7);
    setpx(4, 5);
    load_img();
    exp_q.push_back(18'd35);
    exp_q.push_back(18'd36);
    run_pass("xedge", 1'b1, 3'd2, 2);
    check("xedge_no_wrap", 64'(mem[32]), 64'd0);

    clear_img();
    setpx(5, 0);
    setpx(5, 7);
    load_img();
    exp_q.push_back(18'd43);
    exp_q.push_back(18'd44);
    exp_q.push_back(18'd45);
    exp_q.push_back(18'd46);
    run_pass("clamp", 1'b1, 3'd7, 4);
    check("clamp_mem41", 64'(mem[41]), 64'd0);

    direction = 1'b0;
    gap_len   = '0;
    enable    = 1'b1;
    tick();
    check("gap0_addr1", 64'(address), 64'd0);
    check("gap0_wren1", 64'(wren), 64'd0);
    tick();
    check("gap0_done", 64'(done), 64'd1);
    check("gap0_addr2", 64'(address), 64'd0);
    check("gap0_fill", 64'(fill_count), 64'd0);
    enable = 1'b0;
    tick();
    check("gap0_idle", 64'(done), 64'd0);

    image_a();
    exp_q.push_back(18'd43);
    exp_q.push_back(18'd51);
    direction = 1'b0;
    gap_len   = 3'd2;
    enable    = 1'b1;
    n = 0;
    while (address != 18'd51 && n < 2000) begin
      tick();
      n++;
    end
    check("pause_trigger", 64'(address), 64'd51);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_addr", 64'(address), 64'd51);
      check("pause_wren", 64'(wren), 64'd0);
      check("pause_fill", 64'(fill_count), 64'd0);
    end
    pause = 1'b0;
    wait_done("pause", 4000);
    check("pause_fill_count", 64'(fill_count), 64'd2);
    check("pause_pending", 64'(exp_q.size()), 64'd0);
    check("pause_mem43", 64'(mem[43]), 64'd1);
    check("pause_mem51", 64'(mem[51]), 64'd1);
    enable = 1'b0;
    tick();

    image_a();
    direction = 1'b0;
    gap_len   = 3'd2;
    enable    = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    tick();
    check("restart_addr", 64'(address), 64'd16);
    exp_q.push_back(18'd43);
    exp_q.push_back(18'd51);
    wait_done("restart", 4000);
    check("restart_fill", 64'(fill_count), 64'd2);
    check("restart_pending", 64'(exp_q.size()), 64'd0);
    enable = 1'b0;
    tick();

    image_a();
    exp_q.push_back(18'd43);
    enable = 1'b1;
    n = 0;
    while (fill_count != 18'd1 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_first_fill", 64'(fill_count), 64'd1);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check_zero("abort");
    check("abort_pending", 64'(exp_q.size()), 64'd0);

    dir3 = 1'b0;
    gap3 = 3'd1;
    en3  = 1'b1;
    n = 0;
    while (!done3 && n < 3000) begin
      tick();
      n++;
    end
    check("lat3_cycles", 64'(n), 64'(1 + (H - 2*M) * W * 9));
    check("lat3_no_wren", 64'(wren3_seen), 64'd0);
    check("lat3_fill", 64'(fc3), 64'd0);
    check("lat3_addr", 64'(addr3), 64'd0);
    check("lat3_data", 64'(wd3), 64'd0);
    en3 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
